// File: rtl/gate_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gate_test_sequencer
// Description : Self-test sequencer for a two-input logic gate. Steps A/B
//               through the four input vectors, samples the gate output
//               after a settle time, compares it with a truth table, then
//               holds each vector for a dwell time so the board shows it.
//               Optional macro GATE_SEQ_LOOP_EN makes the sequencer run
//               continuously with a done pulse at every wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_test_sequencer #(
    parameter int         SETTLE_CYCLES = 2,
    parameter int         DWELL_CYCLES  = 100000000,
    parameter logic [3:0] EXPECTED      = 4'b1000,
    parameter int         CNT_W         = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       outAND,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [1:0] vec_idx
);

    localparam logic [2:0] c_stIdle   = 3'd0;
    localparam logic [2:0] c_stSettle = 3'd1;
    localparam logic [2:0] c_stCheck  = 3'd2;
    localparam logic [2:0] c_stDwell  = 3'd3;
    localparam logic [2:0] c_stDone   = 3'd4;

    localparam logic [CNT_W-1:0] c_settleLoad = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_dwellLoad  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cntOne     = CNT_W'(1);
    localparam logic [3:0]       c_expected   = EXPECTED;
    localparam logic             c_noDwell    = (DWELL_CYCLES == 0);

    logic [2:0]       r_state;
    logic [2:0]       w_stateNext;
    logic             r_startQ;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic [1:0]       r_vecIdx;
    logic [1:0]       w_vecNext;
    logic             r_busy;
    logic             w_busyNext;
    logic             r_done;
    logic             w_doneNext;
    logic             r_pass;
    logic             w_passNext;
    logic [3:0]       r_failMask;
    logic [3:0]       w_maskNext;

    logic w_startRise;
    logic w_cntZero;
    logic w_lastVec;
    logic w_mismatch;
    logic w_advance;

    assign w_startRise = start & ~r_startQ;
    assign w_cntZero   = (r_cnt == '0);
    assign w_lastVec   = (r_vecIdx == 2'd3);
    assign w_mismatch  = (outAND != c_expected[r_vecIdx]);
    // Leaving a vector: straight from CHECK when there is no dwell, otherwise
    // when the dwell counter expires.
    assign w_advance   = ((r_state == c_stCheck) && c_noDwell) ||
                         ((r_state == c_stDwell) && w_cntZero);

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_stIdle;
            r_startQ   <= 1'b0;
            r_cnt      <= '0;
            r_vecIdx   <= 2'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_failMask <= 4'b0000;
        end else begin
            r_state    <= w_stateNext;
            r_startQ   <= start;
            r_cnt      <= w_cntNext;
            r_vecIdx   <= w_vecNext;
            r_busy     <= w_busyNext;
            r_done     <= w_doneNext;
            r_pass     <= w_passNext;
            r_failMask <= w_maskNext;
        end
    end

    // Next-state selection for the vector walk.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_stIdle, c_stDone: begin
                if (w_startRise) w_stateNext = c_stSettle;
            end
            c_stSettle: begin
                if (w_cntZero) w_stateNext = c_stCheck;
            end
            c_stCheck: begin
                if (!c_noDwell) w_stateNext = c_stDwell;
            end
            c_stDwell: ;
            default: w_stateNext = c_stIdle;
        endcase
        if (w_advance) begin
`ifdef GATE_SEQ_LOOP_EN
            w_stateNext = c_stSettle;
`else
            w_stateNext = w_lastVec ? c_stDone : c_stSettle;
`endif
        end
    end

    // Next values of the counter and all registered outputs.
    always_comb begin
        w_cntNext  = r_cnt;
        w_vecNext  = r_vecIdx;
        w_busyNext = r_busy;
`ifdef GATE_SEQ_LOOP_EN
        w_doneNext = 1'b0;
`else
        w_doneNext = r_done;
`endif
        w_passNext = r_pass;
        w_maskNext = r_failMask;
        case (r_state)
            c_stIdle, c_stDone: begin
                if (w_startRise) begin
                    w_cntNext  = c_settleLoad;
                    w_vecNext  = 2'd0;
                    w_maskNext = 4'b0000;
                    w_doneNext = 1'b0;
                    w_passNext = 1'b0;
                    w_busyNext = 1'b1;
                end
            end
            c_stSettle, c_stDwell: begin
                if (!w_cntZero) w_cntNext = r_cnt - c_cntOne;
            end
            c_stCheck: begin
                if (w_mismatch) w_maskNext[r_vecIdx] = 1'b1;
                if (!c_noDwell) w_cntNext = c_dwellLoad;
            end
            default: ;
        endcase
        // The mask used for pass already contains this cycle's check result.
        if (w_advance) begin
            if (!w_lastVec) begin
                w_vecNext = r_vecIdx + 2'd1;
                w_cntNext = c_settleLoad;
            end else begin
`ifdef GATE_SEQ_LOOP_EN
                w_vecNext = 2'd0;
                w_cntNext = c_settleLoad;
`else
                w_busyNext = 1'b0;
`endif
                w_doneNext = 1'b1;
                w_passNext = (w_maskNext == 4'b0000);
            end
        end
    end

    assign A         = r_vecIdx[1];
    assign B         = r_vecIdx[0];
    assign vec_idx   = r_vecIdx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_mask = r_failMask;

endmodule
`default_nettype wire
